// File: rtl/sata_link_pkg.sv
// Shared SATA link-layer types: primitive codes, primitive dword values, K-mask.
package sata_link_pkg;

  typedef enum logic [4:0] {
    PRIM_NONE    = 5'd0,
    PRIM_ILLEGAL = 5'd1,
    PRIM_SYNC, PRIM_R_RDY, PRIM_R_IP, PRIM_R_OK, PRIM_R_ERR, PRIM_SOF, PRIM_EOF,
    PRIM_WTRM, PRIM_X_RDY, PRIM_HOLD, PRIM_HOLDA, PRIM_DMAT, PRIM_PMREQ_P,
    PRIM_PMREQ_S, PRIM_PMACK, PRIM_PMNAK, PRIM_ALIGN, PRIM_CONT
  } prim_e;

  typedef enum logic [1:0] {ST_IDLE, ST_NORMAL, ST_CONT} rx_state_e;

  localparam logic [3:0]  K_MASK     = 4'b0001;

  localparam logic [31:0] DW_ALIGN   = 32'h7B4A4ABC;
  localparam logic [31:0] DW_CONT    = 32'h9999AA7C;
  localparam logic [31:0] DW_SYNC    = 32'hB5B5957C;
  localparam logic [31:0] DW_R_RDY   = 32'h4A4A957C;
  localparam logic [31:0] DW_R_IP    = 32'h5555B57C;
  localparam logic [31:0] DW_R_OK    = 32'h3535B57C;
  localparam logic [31:0] DW_R_ERR   = 32'h5656B57C;
  localparam logic [31:0] DW_SOF     = 32'h3737B57C;
  localparam logic [31:0] DW_EOF     = 32'hD5D5B57C;
  localparam logic [31:0] DW_WTRM    = 32'h5858B57C;
  localparam logic [31:0] DW_X_RDY   = 32'h5757B57C;
  localparam logic [31:0] DW_HOLD    = 32'hD5D5AA7C;
  localparam logic [31:0] DW_HOLDA   = 32'h9595AA7C;
  localparam logic [31:0] DW_DMAT    = 32'h3636B57C;
  localparam logic [31:0] DW_PMREQ_P = 32'h1717B57C;
  localparam logic [31:0] DW_PMREQ_S = 32'h7575957C;
  localparam logic [31:0] DW_PMACK   = 32'h9595957C;
  localparam logic [31:0] DW_PMNAK   = 32'hF5F5957C;

endpackage

// File: rtl/link_rx_prim_if.sv
// PHY-side dword stream plus decoded primitive/data stream for link_rx_prim.
// Counter signals exist only with LINK_RX_PRIM_STATS_EN defined.
interface link_rx_prim_if;
  import sata_link_pkg::*;

  logic        phy_ready;
  logic [31:0] data_in;
  logic [3:0]  charisk_in;
  logic [3:0]  err_in;
  logic        prim_valid;
  prim_e       prim_code;
  logic [31:0] data_out;
  logic        data_valid;
  logic        err_out;
  logic        cont_active;
`ifdef LINK_RX_PRIM_STATS_EN
  logic [15:0] align_cnt;
  logic [15:0] err_cnt;
  logic [15:0] cont_cnt;
`endif

  modport master (
    output phy_ready, data_in, charisk_in, err_in,
    input  prim_valid, prim_code, data_out, data_valid, err_out, cont_active
`ifdef LINK_RX_PRIM_STATS_EN
    , input align_cnt, err_cnt, cont_cnt
`endif
  );

  modport slave (
    input  phy_ready, data_in, charisk_in, err_in,
    output prim_valid, prim_code, data_out, data_valid, err_out, cont_active
`ifdef LINK_RX_PRIM_STATS_EN
    , output align_cnt, err_cnt, cont_cnt
`endif
  );
endinterface

// File: rtl/link_prim_match.sv
// Combinational primitive lookup; anything that is not K=0001 plus a table hit is ILLEGAL.
module link_prim_match
  import sata_link_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [3:0]  charisk_in,
  output prim_e       prim_code
);
  always_comb begin
    prim_code = PRIM_ILLEGAL;
    if (charisk_in == K_MASK) begin
      case (data_in)
        DW_ALIGN:   prim_code = PRIM_ALIGN;
        DW_CONT:    prim_code = PRIM_CONT;
        DW_SYNC:    prim_code = PRIM_SYNC;
        DW_R_RDY:   prim_code = PRIM_R_RDY;
        DW_R_IP:    prim_code = PRIM_R_IP;
        DW_R_OK:    prim_code = PRIM_R_OK;
        DW_R_ERR:   prim_code = PRIM_R_ERR;
        DW_SOF:     prim_code = PRIM_SOF;
        DW_EOF:     prim_code = PRIM_EOF;
        DW_WTRM:    prim_code = PRIM_WTRM;
        DW_X_RDY:   prim_code = PRIM_X_RDY;
        DW_HOLD:    prim_code = PRIM_HOLD;
        DW_HOLDA:   prim_code = PRIM_HOLDA;
        DW_DMAT:    prim_code = PRIM_DMAT;
        DW_PMREQ_P: prim_code = PRIM_PMREQ_P;
        DW_PMREQ_S: prim_code = PRIM_PMREQ_S;
        DW_PMACK:   prim_code = PRIM_PMACK;
        DW_PMNAK:   prim_code = PRIM_PMNAK;
        default:    prim_code = PRIM_ILLEGAL;
      endcase
    end
  end
endmodule

// File: rtl/link_rx_prim.sv
// SATA link RX first stage: classify dwords, drop ALIGN, expand CONTp, register outputs.
// Optional saturating counters enabled by LINK_RX_PRIM_STATS_EN.
module link_rx_prim
  import sata_link_pkg::*;
#(
  parameter int DATA_BYTE_WIDTH = 4
) (
  input logic          clk,
  input logic          rst,
  link_rx_prim_if.slave rx
);
  if (DATA_BYTE_WIDTH != 4) begin : g_bad_width
    $error("link_rx_prim: only DATA_BYTE_WIDTH = 4 is supported");
  end

  prim_e       match_code;
  rx_state_e   state_q, state_d;
  prim_e       last_q, last_d;
  prim_e       code_q, code_d;
  logic        pv_q, pv_d, dv_q, dv_d, err_q, err_d, cont_q, cont_d;
  logic [31:0] data_q, data_d;
  logic        is_align, is_data, any_err;

  link_prim_match u_match (
    .data_in    (rx.data_in),
    .charisk_in (rx.charisk_in),
    .prim_code  (match_code)
  );

  assign is_align = (match_code == PRIM_ALIGN);
  assign is_data  = (rx.charisk_in == 4'b0000);
  assign any_err  = |rx.err_in;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pv_d    = 1'b0;
    code_d  = PRIM_NONE;
    dv_d    = 1'b0;
    data_d  = '0;
    err_d   = 1'b0;
    if (!rx.phy_ready) begin
      state_d = ST_IDLE;
      last_d  = PRIM_NONE;
    end else if (state_q == ST_CONT) begin
      // Junk after CONTp is scrambled filler: repeat last_prim, ignore its err_in.
      if (!is_align) begin
        pv_d = 1'b1;
        if (is_data || match_code == PRIM_CONT) begin
          code_d = last_q;
        end else if (match_code == PRIM_ILLEGAL) begin
          code_d  = PRIM_ILLEGAL;
          err_d   = 1'b1;
          state_d = ST_NORMAL;
          last_d  = PRIM_NONE;
        end else begin
          code_d  = match_code;
          err_d   = any_err;
          last_d  = match_code;
          state_d = ST_NORMAL;
        end
      end
    end else begin
      // IDLE with phy_ready high decodes like NORMAL (last_prim is already NONE).
      state_d = ST_NORMAL;
      if (is_data) begin
        dv_d   = 1'b1;
        data_d = rx.data_in;
        err_d  = any_err;
      end else if (!is_align) begin
        pv_d = 1'b1;
        if (match_code == PRIM_ILLEGAL) begin
          code_d = PRIM_ILLEGAL;
          err_d  = 1'b1;
        end else if (match_code == PRIM_CONT) begin
          if (last_q != PRIM_NONE) begin
            code_d  = last_q;
            err_d   = any_err;
            state_d = ST_CONT;
          end else begin
            code_d = PRIM_ILLEGAL;
            err_d  = 1'b1;
          end
        end else begin
          code_d = match_code;
          err_d  = any_err;
          last_d = match_code;
        end
      end
    end
    cont_d = (state_d == ST_CONT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= PRIM_NONE;
      pv_q    <= 1'b0;
      code_q  <= PRIM_NONE;
      dv_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pv_q    <= pv_d;
      code_q  <= code_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cont_q  <= cont_d;
    end
  end

  assign rx.prim_valid  = pv_q;
  assign rx.prim_code   = code_q;
  assign rx.data_valid  = dv_q;
  assign rx.data_out    = data_q;
  assign rx.err_out     = err_q;
  assign rx.cont_active = cont_q;

`ifdef LINK_RX_PRIM_STATS_EN
  logic [15:0] align_cnt_q, align_cnt_d, err_cnt_q, err_cnt_d, cont_cnt_q, cont_cnt_d;

  always_comb begin
    align_cnt_d = align_cnt_q;
    err_cnt_d   = err_cnt_q;
    cont_cnt_d  = cont_cnt_q;
    if (rx.phy_ready && is_align && align_cnt_q != 16'hFFFF) align_cnt_d = align_cnt_q + 16'd1;
    if (err_d && err_cnt_q != 16'hFFFF)                      err_cnt_d   = err_cnt_q + 16'd1;
    if (state_q != ST_CONT && state_d == ST_CONT && cont_cnt_q != 16'hFFFF)
      cont_cnt_d = cont_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_cnt_q <= '0;
      err_cnt_q   <= '0;
      cont_cnt_q  <= '0;
    end else begin
      align_cnt_q <= align_cnt_d;
      err_cnt_q   <= err_cnt_d;
      cont_cnt_q  <= cont_cnt_d;
    end
  end

  assign rx.align_cnt = align_cnt_q;
  assign rx.err_cnt   = err_cnt_q;
  assign rx.cont_cnt  = cont_cnt_q;
`endif
endmodule

// File: tb/tb_link_rx_prim.sv
// Scoreboard bench for link_rx_prim: driver pushes one expected record per dword,
// monitor pops and compares one cycle later.
module tb_link_rx_prim;
  import sata_link_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  link_rx_prim_if bus ();

  link_rx_prim #(.DATA_BYTE_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus.slave)
  );

  typedef struct {
    logic        pv;
    prim_e       code;
    logic        dv;
    logic [31:0] data;
    logic        err;
    logic        cont;
    int          id;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int   checks = 0;
  int   errors = 0;
  int   id_ctr = 0;

  function automatic exp_t ep(prim_e c, logic er, logic ct);
    exp_t x;
    x.pv = 1'b1; x.code = c; x.dv = 1'b0; x.data = '0; x.err = er; x.cont = ct; x.id = 0;
    return x;
  endfunction

  function automatic exp_t ed(logic [31:0] d, logic er);
    exp_t x;
    x.pv = 1'b0; x.code = PRIM_NONE; x.dv = 1'b1; x.data = d; x.err = er; x.cont = 1'b0; x.id = 0;
    return x;
  endfunction

  function automatic exp_t en(logic ct);
    exp_t x;
    x.pv = 1'b0; x.code = PRIM_NONE; x.dv = 1'b0; x.data = '0; x.err = 1'b0; x.cont = ct; x.id = 0;
    return x;
  endfunction

  task automatic send(input logic [31:0] dw, input logic [3:0] k, input logic [3:0] e,
                      input logic rdy, input exp_t x);
    @(negedge clk);
    bus.phy_ready  = rdy;
    bus.data_in    = dw;
    bus.charisk_in = k;
    bus.err_in     = e;
    x.id = id_ctr;
    id_ctr++;
    q.push_back(x);
  endtask

  task automatic prim(input logic [31:0] dw, input exp_t x);
    send(dw, K_MASK, 4'b0000, 1'b1, x);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d records pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.phy_ready = 1'b1; bus.data_in = DW_ALIGN; bus.charisk_in = K_MASK; bus.err_in = 4'b0000;
    #1;
    checks++;
    if (bus.prim_valid !== 1'b0 || bus.data_valid !== 1'b0 || bus.err_out !== 1'b0 ||
        bus.cont_active !== 1'b0 || bus.data_out !== 32'h0 || bus.prim_code !== PRIM_NONE) begin
      errors++;
      $display("FAIL reset_outputs: got pv=%0b dv=%0b err=%0b cont=%0b code=%0d data=%h, expected all 0",
               bus.prim_valid, bus.data_valid, bus.err_out, bus.cont_active, bus.prim_code, bus.data_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle with a pending record, compare the registered outputs.
  always @(posedge clk) begin
    #1;
    if (!rst && q.size() > 0) begin
      mx = q.pop_front();
      checks++;
      if (bus.prim_valid !== mx.pv || (mx.pv && bus.prim_code !== mx.code) ||
          bus.data_valid !== mx.dv || (mx.dv && bus.data_out !== mx.data) ||
          bus.err_out !== mx.err || bus.cont_active !== mx.cont) begin
        errors++;
        $display("FAIL vec%0d: got pv=%0b code=%0d dv=%0b data=%h err=%0b cont=%0b, expected pv=%0b code=%0d dv=%0b data=%h err=%0b cont=%0b",
                 mx.id, bus.prim_valid, bus.prim_code, bus.data_valid, bus.data_out, bus.err_out,
                 bus.cont_active, mx.pv, mx.code, mx.dv, mx.data, mx.err, mx.cont);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bus.phy_ready = 1'b1; bus.data_in = DW_ALIGN; bus.charisk_in = K_MASK; bus.err_in = 4'b0000;
    do_reset();

    // Plain primitives with ALIGNs dropped in between
    prim(DW_SYNC,  ep(PRIM_SYNC, 1'b0, 1'b0));
    prim(DW_ALIGN, en(1'b0));
    prim(DW_ALIGN, en(1'b0));
    prim(DW_R_RDY, ep(PRIM_R_RDY, 1'b0, 1'b0));

    // CONT expansion: junk data is replaced by the repeated X_RDY
    prim(DW_X_RDY, ep(PRIM_X_RDY, 1'b0, 1'b0));
    prim(DW_CONT,  ep(PRIM_X_RDY, 1'b0, 1'b1));
    send(32'h12345678, 4'b0000, 4'b0000, 1'b1, ep(PRIM_X_RDY, 1'b0, 1'b1));
    send(32'hDEADBEEF, 4'b0000, 4'b0000, 1'b1, ep(PRIM_X_RDY, 1'b0, 1'b1));
    prim(DW_SOF,   ep(PRIM_SOF, 1'b0, 1'b0));

    // Junk err_in ignored under CONT; illegal exits CONT and clears last_prim
    prim(DW_HOLD,  ep(PRIM_HOLD, 1'b0, 1'b0));
    prim(DW_CONT,  ep(PRIM_HOLD, 1'b0, 1'b1));
    send(32'hCAFEF00D, 4'b0000, 4'b1111, 1'b1, ep(PRIM_HOLD, 1'b0, 1'b1));
    prim(DW_CONT,  ep(PRIM_HOLD, 1'b0, 1'b1));
    prim(DW_ALIGN, en(1'b1));
    send(32'h0000BC7C, 4'b0011, 4'b0000, 1'b1, ep(PRIM_ILLEGAL, 1'b1, 1'b0));
    prim(DW_CONT,  ep(PRIM_ILLEGAL, 1'b1, 1'b0));
    send(DW_R_OK, K_MASK, 4'b0001, 1'b1, ep(PRIM_R_OK, 1'b1, 1'b0));
    prim(32'h0000007C, ep(PRIM_ILLEGAL, 1'b1, 1'b0));
    prim(DW_EOF,   ep(PRIM_EOF, 1'b0, 1'b0));
    prim(DW_PMNAK, ep(PRIM_PMNAK, 1'b0, 1'b0));
    prim(DW_ALIGN, en(1'b0));
    drain();

    // CONT as first primitive after reset is illegal
    do_reset();
    prim(DW_CONT, ep(PRIM_ILLEGAL, 1'b1, 1'b0));
    send(32'hAABBCCDD, 4'b0000, 4'b0000, 1'b1, ed(32'hAABBCCDD, 1'b0));

    // err_in on a data dword
    prim(DW_SOF, ep(PRIM_SOF, 1'b0, 1'b0));
    send(32'h00000001, 4'b0000, 4'b0100, 1'b1, ed(32'h00000001, 1'b1));
    prim(DW_EOF, ep(PRIM_EOF, 1'b0, 1'b0));

    // phy_ready drop while in CONT: state and last_prim cleared
    prim(DW_X_RDY, ep(PRIM_X_RDY, 1'b0, 1'b0));
    prim(DW_CONT,  ep(PRIM_X_RDY, 1'b0, 1'b1));
    send(32'h11111111, 4'b0000, 4'b0000, 1'b0, en(1'b0));
    send(32'h5A5A5A5A, 4'b0000, 4'b0000, 1'b1, ed(32'h5A5A5A5A, 1'b0));
    prim(DW_CONT,  ep(PRIM_ILLEGAL, 1'b1, 1'b0));
    prim(DW_ALIGN, en(1'b0));
    drain();

`ifdef LINK_RX_PRIM_STATS_EN
    do_reset();
    prim(DW_X_RDY, ep(PRIM_X_RDY, 1'b0, 1'b0));
    prim(DW_CONT,  ep(PRIM_X_RDY, 1'b0, 1'b1));
    send(32'h0, 4'b1111, 4'b0000, 1'b1, ep(PRIM_ILLEGAL, 1'b1, 1'b0));
    prim(DW_ALIGN, en(1'b0));
    drain();
    repeat (70000) @(negedge clk);
    checks++;
    if (bus.align_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL align_cnt_sat: got %h, expected ffff", bus.align_cnt);
    end
    checks++;
    if (bus.err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL err_cnt: got %0d, expected 1", bus.err_cnt);
    end
    checks++;
    if (bus.cont_cnt !== 16'd1) begin
      errors++;
      $display("FAIL cont_cnt: got %0d, expected 1", bus.cont_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.align_cnt !== 16'h0 || bus.err_cnt !== 16'h0 || bus.cont_cnt !== 16'h0) begin
      errors++;
      $display("FAIL cnt_reset: got align=%h err=%h cont=%h, expected 0", bus.align_cnt, bus.err_cnt, bus.cont_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/link_rx_prim.md
Name: link_rx_prim

Overview:
- First receive stage of the SATA link layer; sits directly downstream of the PHY and consumes its 32-bit dword stream (data, K-flags, per-byte error).
- Classifies each dword as a primitive, a payload data word, or an error. Drops ALIGN pairs.
- Implements CONTp suppression: the last primitive is repeated, and scrambled junk after CONTp is discarded.
- Presents a clean, one-cycle-registered primitive/data stream to the link state machine.

Parameters:
DATA_BYTE_WIDTH, 4, bytes per dword; only 4 is supported, and any other value is rejected at elaboration.

Ports:
clk  in  1  sata clock (usrclk2 domain, same as the PHY output clock)
rst  in  1  reset; asynchronous, active-high
phy_ready  in  1  PHY link established; low forces the IDLE state
data_in  in  32  received dword; byte 0 in bits [7:0]
charisk_in  in  4  per-byte K-character flags
err_in  in  4  per-byte disparity/not-in-table error
prim_valid  out  1  prim_code is valid this cycle
prim_code  out  5  decoded primitive, enum from the package
data_out  out  32  payload dword
data_valid  out  1  data_out is valid this cycle
err_out  out  1  decode error on the dword producing this cycle's output
cont_active  out  1  CONTp suppression is in effect

Behaviour:
- Reset (async): all outputs are 0, state is IDLE, last_prim is NONE.
- Latency: exactly one clk from input dword to registered output.
- Only one of prim_valid and data_valid can be high in a cycle.
- Classification:
  - Primitive: charisk_in == 4'b0001 and the dword matches a table entry.
  - ALIGN = 0x7B4A4ABC
  - CONT = 0x9999AA7C
  - SYNC = 0xB5B5957C
  - R_RDY = 0x4A4A957C
  - R_IP = 0x5555B57C
  - R_OK = 0x3535B57C
  - R_ERR = 0x5656B57C
  - SOF = 0x3737B57C
  - EOF = 0xD5D5B57C
  - WTRM = 0x5858B57C
  - X_RDY = 0x5757B57C
  - HOLD = 0xD5D5AA7C
  - HOLDA = 0x9595AA7C
  - DMAT = 0x3636B57C
  - PMREQ_P = 0x1717B57C
  - PMREQ_S = 0x7575957C
  - PMACK = 0x9595957C
  - PMNAK = 0xF5F5957C
  - Data: charisk_in == 0.
  - Illegal: any other charisk pattern, or charisk 0001 with no table match.
- State IDLE:
  - Entered whenever phy_ready == 0 or on reset. This holds even mid-CONT.
  - Outputs are 0 and last_prim is cleared to NONE.
  - Goes to NORMAL on the cycle after phy_ready == 1.
- State NORMAL:
  - ALIGN: no output and no state change.
  - Data: data_out = data_in, data_valid = 1.
  - Primitive other than ALIGN/CONT: prim_valid = 1, prim_code = that primitive, and last_prim is updated.
  - CONT: if last_prim != NONE, go to CONT_ACTIVE and output prim_valid = 1 with prim_code = last_prim. If last_prim == NONE, output prim_code = ILLEGAL with err_out = 1 and stay in NORMAL.
  - Illegal dword: prim_valid = 1, prim_code = ILLEGAL, err_out = 1.
- State CONT_ACTIVE (cont_active = 1):
  - Data dwords and repeated CONTs: discarded, but prim_valid = 1 with prim_code = last_prim every such cycle.
  - ALIGN: no output.
  - Any other valid primitive P: output P, last_prim = P, return to NORMAL.
  - Illegal dword: output ILLEGAL with err_out = 1, return to NORMAL, last_prim = NONE.
- err_in: any bit set forces err_out = 1 on that output cycle, OR-ed with the decode error.
  - Classification still uses the received bytes.
  - In CONT_ACTIVE, err_in on junk dwords is ignored (err_out = 0), because the junk is discarded.

Optional Feature:
LINK_RX_PRIM_STATS_EN
- Defined: adds outputs align_cnt[15:0], err_cnt[15:0], cont_cnt[15:0].
  - align_cnt counts dropped ALIGNs.
  - err_cnt counts cycles with err_out = 1.
  - cont_cnt counts entries into CONT_ACTIVE.
  - All three are saturating at 0xFFFF, cleared by rst, and not cleared by phy_ready.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package sata_link_pkg holds:
  - prim_code enum: NONE=0, ILLEGAL=1, then SYNC..PMNAK plus ALIGN and CONT;
  - 32-bit primitive dword localparams;
  - the K-mask constant 4'b0001.
- Sub-module link_prim_match: purely combinational data_in/charisk_in -> prim_code lookup, reused later by the TX side for checking.
- State machine and output registers live in link_rx_prim.

Test Plan:
1. phy_ready = 1; send SYNC, ALIGN, ALIGN, R_RDY -> prim_code SYNC, then R_RDY on the next output cycle; no output for the ALIGNs; err_out = 0 throughout.
2. Send X_RDY, CONT, 0x12345678 (K=0), 0xDEADBEEF (K=0), SOF -> X_RDY output 4 consecutive cycles (cont_active = 1 for the middle 3), then SOF with cont_active = 0; data_valid never asserted.
3. After reset, send CONT first -> prim_code ILLEGAL, err_out = 1, state stays NORMAL; next data 0xAABBCCDD -> data_valid = 1, data_out = 0xAABBCCDD.
4. Send SOF, data 0x00000001 with err_in = 4'b0100, then EOF -> data_valid = 1 with err_out = 1; EOF output clean.
5. In CONT_ACTIVE, drop phy_ready for 1 cycle, then send data 0x5A5A5A5A -> outputs 0 and cont_active = 0 in the cycle after the drop; the data is forwarded with data_valid = 1, and no repeat of last_prim.
6. (LINK_RX_PRIM_STATS_EN) send 70000 ALIGNs -> align_cnt saturates at 0xFFFF; assert rst -> all counters 0.
